ca_code_gen: RTL and testbench

- GPS L1 C/A code generator; consumer of the half-chip enable produced by the tracking channel's code NCO.
- Steps G1/G2 LFSRs once per chip, i.e. on every second hc_enable pulse.
- Produces early/prompt/late code replicas at half-chip spacing, the full-chip enable and the 1 ms epoch dump.
- Supports PRN key load, code-phase slew, and a TIC-latched coarse code phase for the channel register block.

---
 rtl/ca_code_gen.sv | 149 ++++++++++++++
 tb/tb_ca_code_gen.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_code_gen.sv
// GPS L1 C/A code generator: G1/G2 LFSRs stepped once per chip (every second half-chip enable),
// early/prompt/late replicas at half-chip spacing, full-chip enable and 1 ms epoch dump.
// Latency: one clk from an accepted hc_enable to replicas/strobes. No backpressure: hc_enable is
// swallowed while a slew is pending. Optional slew logic is built only when CODE_SLEW_EN is defined.
module ca_code_gen #(
  parameter logic [7:0]  PRN_RESET_KEY = 8'h26,
  parameter int unsigned SLEW_W        = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hc_enable,
  input  logic              prn_key_enable,
  input  logic [7:0]        prn_key,
  input  logic              slew_enable,
  input  logic [SLEW_W-1:0] slew,
  input  logic              tic_enable,
  output logic              early,
  output logic              prompt,
  output logic              late,
  output logic              fc_enable,
  output logic              dump_enable,
  output logic              slewing,
  output logic [10:0]       code_phase
);

  localparam logic [9:0] CHIP_LAST = 10'd1022;

  logic [7:0]  key_q;
  logic [10:1] g1_q;
  logic [10:1] g2_q;
  logic [2:0]  srq_q;
  logic        hc_phase_q;
  logic [9:0]  chip_cnt_q;

  logic        slew_busy;
  logic        advance;
  logic        ca;
  logic        g1_fb;
  logic        g2_fb;

  // G2 tap select; indices outside 1..10 contribute nothing to the code
  function automatic logic g2_tap(input logic [10:1] g, input logic [3:0] idx);
    logic t;
    t = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (idx == 4'(i)) t = g[i];
    end
    return t;
  endfunction

  assign g1_fb   = g1_q[3] ^ g1_q[10];
  assign g2_fb   = g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10];
  assign ca      = g1_q[10] ^ g2_tap(g2_q, key_q[7:4]) ^ g2_tap(g2_q, key_q[3:0]);

  // A key load drops any coincident half-chip enable
  assign advance = hc_enable && !slew_busy && !prn_key_enable;

  assign early   = srq_q[0];
  assign prompt  = srq_q[1];
  assign late    = srq_q[2];

  // Code state: key load restarts the sequence, otherwise shift replicas each half-chip and step LFSRs each chip
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q       <= PRN_RESET_KEY;
      g1_q        <= '1;
      g2_q        <= '1;
      srq_q       <= '0;
      hc_phase_q  <= 1'b0;
      chip_cnt_q  <= '0;
      fc_enable   <= 1'b0;
      dump_enable <= 1'b0;
    end else begin
      fc_enable   <= 1'b0;
      dump_enable <= 1'b0;
      if (prn_key_enable) begin
        key_q      <= prn_key;
        g1_q       <= '1;
        g2_q       <= '1;
        srq_q      <= '0;
        hc_phase_q <= 1'b0;
        chip_cnt_q <= '0;
      end else if (advance) begin
        srq_q      <= {srq_q[1:0], ca};
        hc_phase_q <= ~hc_phase_q;
        if (hc_phase_q) begin
          fc_enable <= 1'b1;
          if (chip_cnt_q == CHIP_LAST) begin
            // Epoch boundary: reload both registers rather than relying on the natural 1023 wrap
            chip_cnt_q  <= '0;
            g1_q        <= '1;
            g2_q        <= '1;
            dump_enable <= 1'b1;
          end else begin
            chip_cnt_q <= chip_cnt_q + 10'd1;
            g1_q       <= {g1_q[9:1], g1_fb};
            g2_q       <= {g2_q[9:1], g2_fb};
          end
        end
      end
    end
  end

  // TIC snapshot of the coarse phase, taken before any same-cycle advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_phase <= '0;
    end else if (tic_enable) begin
      code_phase <= {chip_cnt_q, hc_phase_q};
    end
  end

`ifdef CODE_SLEW_EN
  logic [SLEW_W-1:0] slew_cnt_q;
  logic [SLEW_W-1:0] slew_cnt_d;

  assign slew_busy = (slew_cnt_q != '0);

  // Next slew count: key load clears, a new load overrides (no decrement), else swallow one enable
  always_comb begin
    slew_cnt_d = slew_cnt_q;
    if (prn_key_enable) begin
      slew_cnt_d = '0;
    end else if (slew_enable) begin
      slew_cnt_d = slew;
    end else if (hc_enable && slew_busy) begin
      slew_cnt_d = slew_cnt_q - {{(SLEW_W-1){1'b0}}, 1'b1};
    end
  end

  // Slew counter and its registered busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slew_cnt_q <= '0;
      slewing    <= 1'b0;
    end else begin
      slew_cnt_q <= slew_cnt_d;
      slewing    <= (slew_cnt_d != '0);
    end
  end
`else
  logic unused_slew;

  assign slew_busy   = 1'b0;
  assign slewing     = 1'b0;
  assign unused_slew = ^{slew_enable, slew};
`endif

endmodule

// File: tb/tb_ca_code_gen.sv
// Self-checking bench for ca_code_gen against a sequence-level C/A model.
module tb_ca_code_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        hc_enable;
  logic        prn_key_enable;
  logic [7:0]  prn_key;
  logic        slew_enable;
  logic [10:0] slew;
  logic        tic_enable;
  logic        early, prompt, late;
  logic        fc_enable, dump_enable, slewing;
  logic [10:0] code_phase;

  ca_code_gen #(.PRN_RESET_KEY(8'h26), .SLEW_W(11)) dut (
    .clk(clk), .rst(rst), .hc_enable(hc_enable), .prn_key_enable(prn_key_enable),
    .prn_key(prn_key), .slew_enable(slew_enable), .slew(slew), .tic_enable(tic_enable),
    .early(early), .prompt(prompt), .late(late), .fc_enable(fc_enable),
    .dump_enable(dump_enable), .slewing(slewing), .code_phase(code_phase)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] PRN1_HEAD = 10'b1100100000;  // octal 1440
  localparam logic [9:0] PRN2_HEAD = 10'b1110010000;  // octal 1620

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: one code period as a chip table, plus half-chips advanced since restart
  bit   chip_tab [0:1022];
  int   n_adv;
  int   slew_m;
  int   cp_pre;
  bit   fc_exp, dump_exp, fc_seen, dump_seen, fc_tail, dump_tail;

  // Chips from the register sequences: s[t] = s[t-3]^s[t-10] (G1) etc., all-ones history
  task automatic build_table(input logic [7:0] key);
    bit s1 [0:1032];
    bit s2 [0:1032];
    int a, b;
    a = int'(key[7:4]);
    b = int'(key[3:0]);
    for (int j = 0; j < 10; j++) begin
      s1[j] = 1'b1;
      s2[j] = 1'b1;
    end
    for (int t = 0; t < 1023; t++) begin
      chip_tab[t] = s1[t] ^ ((a >= 1 && a <= 10) ? s2[t + 10 - a] : 1'b0)
                          ^ ((b >= 1 && b <= 10) ? s2[t + 10 - b] : 1'b0);
      s1[t + 10] = s1[t + 7] ^ s1[t];
      s2[t + 10] = s2[t + 8] ^ s2[t + 7] ^ s2[t + 4] ^ s2[t + 2] ^ s2[t + 1] ^ s2[t];
    end
  endtask

  task automatic model_restart(input logic [7:0] key);
    build_table(key);
    n_adv  = 0;
    slew_m = 0;
  endtask

  function automatic bit hseq(input int m);
    if (m < 0) return 1'b0;
    return chip_tab[(m / 2) % 1023];
  endfunction

  function automatic logic [2:0] exp_eplt();
    return {hseq(n_adv - 1), hseq(n_adv - 2), hseq(n_adv - 3)};
  endfunction

  function automatic bit exp_slw();
`ifdef CODE_SLEW_EN
    return slew_m != 0;
`else
    return 1'b0;
`endif
  endfunction

  // All stimulus tasks start and end 1 time unit after a rising edge
  task automatic hc_pulse(input bit tic);
    int idle;
    cp_pre = n_adv % 2046;
    hc_enable = 1'b1;
    tic_enable = tic;
    @(posedge clk); #1;
    hc_enable = 1'b0;
    tic_enable = 1'b0;
    fc_exp = 1'b0;
    dump_exp = 1'b0;
    if (slew_m > 0) slew_m--;
    else begin
      n_adv++;
      fc_exp   = (n_adv % 2 == 0);
      dump_exp = (n_adv % 2046 == 0);
    end
    fc_seen = fc_enable;
    dump_seen = dump_enable;
    @(posedge clk); #1;
    fc_tail = fc_enable;
    dump_tail = dump_enable;
    idle = int'($urandom_range(0, 2));
    for (int i = 0; i < idle; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_key(input logic [7:0] key, input bit with_hc);
    prn_key_enable = 1'b1;
    prn_key = key;
    hc_enable = with_hc;
    @(posedge clk); #1;
    prn_key_enable = 1'b0;
    hc_enable = 1'b0;
    @(posedge clk); #1;
    model_restart(key);
  endtask

  task automatic slew_load(input int val, input bit with_hc);
    slew_enable = 1'b1;
    slew = 11'(val);
    hc_enable = with_hc;
    @(posedge clk); #1;
    slew_enable = 1'b0;
    hc_enable = 1'b0;
    @(posedge clk); #1;
`ifdef CODE_SLEW_EN
    slew_m = val;
`endif
  endtask

  task automatic tic_only();
    cp_pre = n_adv % 2046;
    tic_enable = 1'b1;
    @(posedge clk); #1;
    tic_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({early, prompt, late, fc_enable, dump_enable, slewing, code_phase} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {early, prompt, late, fc_enable, dump_enable, slewing, code_phase});
    end
    rst = 1'b0;
    model_restart(8'h26);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({early, prompt, late, fc_enable, dump_enable, slewing} !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: got %b expected 000000",
               {early, prompt, late, fc_enable, dump_enable, slewing});
    end
  endtask

  // Prefix check plus per-pulse model comparison; also early/late half-chip offset vs prompt
  task automatic test_prn1();
    logic [9:0] head;
    logic [2:0] obs [1:20];
    int bad;
    head = '0;
    bad = 0;
    for (int i = 1; i <= 20; i++) begin
      hc_pulse(1'b0);
      if ({early, prompt, late, fc_seen, dump_seen, fc_tail} !== {exp_eplt(), fc_exp, dump_exp, 1'b0}) bad++;
      obs[i] = {early, prompt, late};
      if (i % 2 == 0) head[10 - i / 2] = prompt;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL prn1_stream: got %0d mismatching pulses expected 0", bad);
    end
    tests_run++;
    if (head !== PRN1_HEAD) begin
      tests_failed++;
      $display("FAIL prn1_head: got %o expected %o", head, PRN1_HEAD);
    end
    bad = 0;
    for (int i = 1; i < 20; i++)
      if (obs[i][2] !== obs[i + 1][1] || obs[i + 1][0] !== obs[i][1]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL early_late_offset: got %0d bad pairs expected 0", bad);
    end
  endtask

  task automatic test_prn2();
    logic [9:0] head;
    int bad;
    head = '0;
    bad = 0;
    for (int i = 0; i < 5; i++) hc_pulse(1'b0);
    load_key(8'h37, 1'b1);
    tic_only();
    tests_run++;
    if ({early, prompt, late, code_phase} !== 14'd0) begin
      tests_failed++;
      $display("FAIL prn2_load_clear: got %b expected all zero", {early, prompt, late, code_phase});
    end
    for (int i = 1; i <= 20; i++) begin
      hc_pulse(1'b0);
      if ({early, prompt, late, fc_seen, dump_seen} !== {exp_eplt(), fc_exp, dump_exp}) bad++;
      if (i % 2 == 0) head[10 - i / 2] = prompt;
    end
    tests_run++;
    if (head !== PRN2_HEAD || bad != 0) begin
      tests_failed++;
      $display("FAIL prn2_head: got %o (%0d bad pulses) expected %o", head, bad, PRN2_HEAD);
    end
    tic_only();
    tests_run++;
    if (code_phase !== 11'd20) begin
      tests_failed++;
      $display("FAIL prn2_chip_count: got %0d expected 20", code_phase);
    end
  endtask

  task automatic test_tap_range();
    logic [7:0] keys [0:2];
    int bad;
    keys[0] = 8'h0B;
    keys[1] = 8'hA1;
    keys[2] = 8'h5F;
    for (int k = 0; k < 3; k++) begin
      load_key(keys[k], 1'b0);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
        hc_pulse(1'b0);
        if ({early, prompt, late, fc_seen} !== {exp_eplt(), fc_exp}) bad++;
      end
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("FAIL tap_range key=%h: got %0d bad pulses expected 0", keys[k], bad);
      end
    end
  endtask

  task automatic test_tic();
    int bad;
    bit t;
    bad = 0;
    load_key(8'h26, 1'b0);
    for (int i = 0; i < 199; i++) begin
      t = ($urandom_range(0, 7) == 0);
      hc_pulse(t);
      if (t && code_phase !== 11'(cp_pre)) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL tic_random: got %0d bad samples expected 0", bad);
    end
    hc_pulse(1'b1);
    tests_run++;
    if (code_phase !== 11'd199) begin
      tests_failed++;
      $display("FAIL tic_coincident: got %0d expected 199", code_phase);
    end
    tic_only();
    tests_run++;
    if (code_phase !== 11'd200) begin
      tests_failed++;
      $display("FAIL tic_after_step: got %0d expected 200", code_phase);
    end
  endtask

`ifdef CODE_SLEW_EN
  task automatic test_slew();
    int bad, v, v2;
    load_key(8'h26, 1'b0);
    for (int i = 0; i < 10; i++) hc_pulse(1'b0);
    slew_load(3, 1'b0);
    tests_run++;
    if (slewing !== 1'b1) begin
      tests_failed++;
      $display("FAIL slew_start: got slewing=%b expected 1", slewing);
    end
    for (int k = 1; k <= 3; k++) begin
      hc_pulse(k == 2);
      tests_run++;
      if ({early, prompt, late, fc_seen, dump_seen, slewing} !== {exp_eplt(), 2'b00, exp_slw()}
          || (k == 2 && code_phase !== 11'd10)) begin
        tests_failed++;
        $display("FAIL slew_swallow%0d: got %b cp=%0d expected %b cp=10", k,
                 {early, prompt, late, fc_seen, dump_seen, slewing}, code_phase,
                 {exp_eplt(), 2'b00, exp_slw()});
      end
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      hc_pulse(1'b0);
      if ({early, prompt, late, fc_seen, slewing} !== {exp_eplt(), fc_exp, 1'b0}) bad++;
    end
    tests_run++;
    if (bad != 0 || n_adv != 22) begin
      tests_failed++;
      $display("FAIL slew_resume: got %0d bad pulses expected 0", bad);
    end
    bad = 0;
    for (int r = 0; r < 4; r++) begin
      v = int'($urandom_range(2, 6));
      slew_load(v, 1'b0);
      hc_pulse(1'b0);
      v2 = int'($urandom_range(1, 5));
      slew_load(v2, 1'b1);
      if (slewing !== 1'b1 || {early, prompt, late} !== exp_eplt()) bad++;
      for (int i = 0; i < v2 + 2; i++) begin
        hc_pulse(1'b0);
        if ({early, prompt, late, fc_seen, slewing} !== {exp_eplt(), fc_exp, exp_slw()}) bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL slew_reload: got %0d bad samples expected 0", bad);
    end
    slew_load(5, 1'b0);
    slew_load(0, 1'b0);
    hc_pulse(1'b0);
    tests_run++;
    if ({slewing, early, prompt, late} !== {1'b0, exp_eplt()}) begin
      tests_failed++;
      $display("FAIL slew_cancel: got %b expected %b", {slewing, early, prompt, late}, {1'b0, exp_eplt()});
    end
    slew_load(4, 1'b0);
    load_key(8'h26, 1'b0);
    tests_run++;
    if (slewing !== 1'b0) begin
      tests_failed++;
      $display("FAIL slew_key_clear: got slewing=%b expected 0", slewing);
    end
  endtask
`else
  task automatic test_slew();
    int bad;
    bad = 0;
    load_key(8'h26, 1'b0);
    slew_load(3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      hc_pulse(1'b0);
      if ({early, prompt, late, fc_seen, slewing} !== {exp_eplt(), fc_exp, 1'b0}) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL slew_ignored: got %0d bad pulses expected 0", bad);
    end
  endtask
`endif

  task automatic test_epoch();
    int bad, fc_cnt, dump_cnt, dump_at, tail_bad;
    logic [9:0] head;
    bad = 0; fc_cnt = 0; dump_cnt = 0; dump_at = -1; tail_bad = 0; head = '0;
    load_key(8'h26, 1'b0);
    for (int i = 1; i <= 2046; i++) begin
      hc_pulse(1'b0);
      if (fc_seen) fc_cnt++;
      if (dump_seen) begin
        dump_cnt++;
        dump_at = i;
      end
      if (fc_tail || dump_tail) tail_bad++;
      if ({early, prompt, late, fc_seen, dump_seen} !== {exp_eplt(), fc_exp, dump_exp}) bad++;
    end
    tests_run++;
    if (fc_cnt != 1023) begin
      tests_failed++;
      $display("FAIL epoch_fc_count: got %0d expected 1023", fc_cnt);
    end
    tests_run++;
    if (dump_cnt != 1 || dump_at != 2046) begin
      tests_failed++;
      $display("FAIL epoch_dump: got %0d dumps at pulse %0d expected 1 at 2046", dump_cnt, dump_at);
    end
    tests_run++;
    if (bad != 0 || tail_bad != 0) begin
      tests_failed++;
      $display("FAIL epoch_stream: got %0d bad, %0d back-to-back expected 0", bad, tail_bad);
    end
    for (int i = 1; i <= 20; i++) begin
      hc_pulse(1'b0);
      if (i % 2 == 0) head[10 - i / 2] = prompt;
    end
    tests_run++;
    if (head !== PRN1_HEAD) begin
      tests_failed++;
      $display("FAIL epoch_repeat: got %o expected %o", head, PRN1_HEAD);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] head;
    int bad;
    head = '0;
    bad = 0;
    load_key(8'h37, 1'b0);
    for (int i = 0; i < 800; i++) hc_pulse(1'b0);
    tic_only();
    tests_run++;
    if (code_phase !== 11'd800) begin
      tests_failed++;
      $display("FAIL mid_code_phase: got %0d expected 800", code_phase);
    end
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({early, prompt, late, fc_enable, dump_enable, slewing, code_phase} !== 17'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_async: got %b expected all zero",
               {early, prompt, late, fc_enable, dump_enable, slewing, code_phase});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    model_restart(8'h26);
    for (int i = 1; i <= 20; i++) begin
      hc_pulse(1'b0);
      if ({early, prompt, late} !== exp_eplt()) bad++;
      if (i % 2 == 0) head[10 - i / 2] = prompt;
    end
    tests_run++;
    if (head !== PRN1_HEAD || bad != 0) begin
      tests_failed++;
      $display("FAIL mid_reset_restart: got %o (%0d bad) expected %o", head, bad, PRN1_HEAD);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    hc_enable = 1'b0;
    prn_key_enable = 1'b0;
    prn_key = 8'h00;
    slew_enable = 1'b0;
    slew = '0;
    tic_enable = 1'b0;
    test_reset();
    test_prn1();
    test_prn2();
    test_tap_range();
    test_tic();
    test_slew();
    test_epoch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
